// File: rtl/seq_alu.sv
// Sequential accumulator ALU: single-cycle arithmetic, logic, shift and compare ops on ACC.
// Define SEQ_ALU_MUL_EN to build in the W-cycle shift-add multiply (opcode C) and the HI register.
module seq_alu #(
    parameter  int W  = 8,
    localparam int SW = $clog2(W)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] operand,
    output logic [W-1:0] acc_out,
    output logic [W-1:0] hi_out,
    output logic         carry,
    output logic         eq,
    output logic         busy,
    output logic         done
);

    logic [W-1:0] acc_reg;
    logic         c_reg;
    logic         eq_reg;
    logic         done_reg;
    logic [W:0]   add_sum;
    logic [W:0]   sub_sum;

    assign add_sum = {1'b0, acc_reg} + {1'b0, operand} + {{W{1'b0}}, c_reg};
    assign sub_sum = {1'b0, acc_reg} + {1'b0, ~operand} + {{W{1'b0}}, c_reg};

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t        state_reg;
    logic [W-1:0]  hi_reg;
    logic [W-1:0]  mcand_reg;
    logic [SW-1:0] cnt_reg;
    logic          busy_reg;
    logic [W:0]    psum;

    // One shift-add step: {HI,ACC} is the product/multiplier register, ACC[0] picks the addend.
    assign psum = {1'b0, hi_reg} + {1'b0, (acc_reg[0] ? mcand_reg : {W{1'b0}})};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_reg  <= '0;
            c_reg    <= 1'b0;
            eq_reg   <= 1'b0;
            done_reg <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            state_reg <= IDLE;
            hi_reg    <= '0;
            mcand_reg <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            if (state_reg == MUL) begin
                {hi_reg, acc_reg} <= {psum, acc_reg[W-1:1]};
                cnt_reg           <= cnt_reg + 1'b1;
                if (cnt_reg == SW'(W - 1)) begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
            end else
`endif
            if (start) begin
                done_reg <= 1'b1;
                case (op)
                    4'h0: acc_reg <= operand;
                    4'h1: {c_reg, acc_reg} <= add_sum;
                    4'h2: {c_reg, acc_reg} <= sub_sum;
                    4'h3: acc_reg <= operand << acc_reg[SW-1:0];
                    4'h4: acc_reg <= operand >> acc_reg[SW-1:0];
                    4'h5: begin acc_reg <= acc_reg & operand; c_reg <= 1'b0; end
                    4'h6: begin acc_reg <= acc_reg | operand; c_reg <= 1'b0; end
                    4'h7: begin acc_reg <= acc_reg ^ operand; c_reg <= 1'b0; end
                    4'h8: eq_reg <= (operand == acc_reg);
                    4'h9: eq_reg <= (operand <  acc_reg);
                    4'hA: eq_reg <= (operand >= acc_reg);
                    4'hB: eq_reg <= (operand >  acc_reg);
                    4'hC: begin
`ifdef SEQ_ALU_MUL_EN
                        state_reg <= MUL;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                        hi_reg    <= '0;
                        mcand_reg <= operand;
                        cnt_reg   <= '0;
`endif
                    end
                    4'hD: c_reg <= 1'b0;
                    4'hE: c_reg <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign acc_out = acc_reg;
    assign carry   = c_reg;
    assign eq      = eq_reg;
    assign done    = done_reg;
`ifdef SEQ_ALU_MUL_EN
    assign hi_out  = hi_reg;
    assign busy    = busy_reg;
`else
    assign hi_out  = '0;
    assign busy    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: an abstract op-level model checked every cycle plus literal spot checks.
// Covers the SEQ_ALU_MUL_EN build when that macro is defined, the plain build otherwise.
module tb_seq_alu;
    localparam int W = 8;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] operand;
    logic [W-1:0] acc_out;
    logic [W-1:0] hi_out;
    logic         carry;
    logic         eq;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Model state
    logic [W-1:0]   m_acc = '0;
    logic [W-1:0]   m_hi  = '0;
    logic           m_c   = 1'b0;
    logic           m_eq  = 1'b0;
    logic           m_done = 1'b0;
    logic           m_busy = 1'b0;
    int             mul_left = 0;
    logic [2*W-1:0] mul_prod = '0;

    seq_alu #(.W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .operand (operand),
        .acc_out (acc_out),
        .hi_out  (hi_out),
        .carry   (carry),
        .eq      (eq),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Operation-level reference: whole-op results, multiply as a W-edge countdown to a product.
    task automatic model_step();
        int s;
        if (!reset_n) begin
            m_acc = '0; m_hi = '0; m_c = 1'b0; m_eq = 1'b0; m_done = 1'b0;
            mul_left = 0;
        end else begin
            m_done = 1'b0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    m_acc  = mul_prod[W-1:0];
                    m_hi   = mul_prod[2*W-1:W];
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_done = 1'b1;
                case (op)
                    4'h0: m_acc = operand;
                    4'h1: begin
                        s = int'(m_acc) + int'(operand) + int'(m_c);
                        m_c = (s >= (1 << W));
                        m_acc = W'(s);
                    end
                    4'h2: begin
                        s = int'(m_acc) - int'(operand) - (1 - int'(m_c));
                        m_c = (s >= 0);
                        m_acc = W'(s);
                    end
                    4'h3: m_acc = W'(int'(operand) << (int'(m_acc) % W));
                    4'h4: m_acc = W'(int'(operand) >> (int'(m_acc) % W));
                    4'h5: begin m_acc = m_acc & operand; m_c = 1'b0; end
                    4'h6: begin m_acc = m_acc | operand; m_c = 1'b0; end
                    4'h7: begin m_acc = m_acc ^ operand; m_c = 1'b0; end
                    4'h8: m_eq = (operand == m_acc);
                    4'h9: m_eq = (operand <  m_acc);
                    4'hA: m_eq = (operand >= m_acc);
                    4'hB: m_eq = (operand >  m_acc);
                    4'hC: begin
`ifdef SEQ_ALU_MUL_EN
                        mul_prod = (2*W)'(int'(m_acc) * int'(operand));
                        mul_left = W;
                        m_done   = 1'b0;
`endif
                    end
                    4'hD: m_c = 1'b0;
                    4'hE: m_c = 1'b1;
                    default: ;
                endcase
            end
        end
        m_busy = (mul_left > 0);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Cycle-by-cycle comparison; ACC/HI are undefined while a multiply runs.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("cyc_done",  done,  m_done);
            check("cyc_busy",  busy,  m_busy);
            check("cyc_carry", carry, m_c);
            check("cyc_eq",    eq,    m_eq);
            if (!m_busy) begin
                check("cyc_acc", acc_out, m_acc);
                check("cyc_hi",  hi_out,  m_hi);
            end
        end
    end

    // Present a command for one edge; returns at the following negedge with results visible.
    task automatic do_op(input logic [3:0] o, input logic [W-1:0] v);
        start = 1'b1; op = o; operand = v;
        @(negedge clk);
        start = 1'b0;
        $display("op=%h operand=%h -> acc=%h hi=%h c=%b eq=%b busy=%b done=%b",
                 o, v, acc_out, hi_out, carry, eq, busy, done);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acc"},  acc_out, 0);
        check({tag, "_hi"},   hi_out,  0);
        check({tag, "_c"},    carry,   0);
        check({tag, "_eq"},   eq,      0);
        check({tag, "_busy"}, busy,    0);
        check({tag, "_done"}, done,    0);
    endtask

    logic [3:0]   tbl_op [12] = '{4'h0, 4'h1, 4'h2, 4'h7, 4'h4, 4'h3, 4'hE, 4'h1, 4'h9, 4'hB, 4'h6, 4'hA};
    logic [W-1:0] tbl_v  [12] = '{8'h12, 8'h34, 8'h01, 8'hFF, 8'hF0, 8'h0F, 8'h00, 8'h7F, 8'h10, 8'h99, 8'h81, 8'h22};

    initial begin
        int n;
        reset_n = 1'b0; start = 1'b0; op = 4'h0; operand = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check_all_zero("reset");
        reset_n = 1'b1;

        // Add with carry out
        do_op(4'h0, 8'hF0);
        do_op(4'h1, 8'h20);
        check("add_acc", acc_out, 8'h10);
        check("add_c",   carry,   1);
        check("add_done", done,   1);
        @(negedge clk);
        check("add_done_clear", done, 0);

        // Subtract with borrow
        do_op(4'h0, 8'h05);
        do_op(4'hE, 8'h00);
        do_op(4'h2, 8'h07);
        check("sub_acc", acc_out, 8'hFE);
        check("sub_c",   carry,   0);

        // Shifts, amount from ACC[2:0]
        do_op(4'h0, 8'h03);
        do_op(4'h3, 8'h81);
        check("lsl_acc", acc_out, 8'h08);
        do_op(4'h0, 8'h0B);
        do_op(4'h4, 8'h80);
        check("lsr_acc", acc_out, 8'h10);
        do_op(4'h0, 8'h08);
        do_op(4'h3, 8'h5A);
        check("lsl0_acc", acc_out, 8'h5A);

        // Logic ops clear carry
        do_op(4'hE, 8'h00);
        do_op(4'h0, 8'hF0);
        do_op(4'h5, 8'h3C);
        check("and_acc", acc_out, 8'h30);
        check("and_c",   carry,   0);
        do_op(4'h6, 8'h0F);
        do_op(4'h7, 8'hFF);
        check("xor_acc", acc_out, 8'hC0);

        // Compares against ACC=C0
        do_op(4'h8, 8'hC0); check("ceq", eq, 1);
        do_op(4'h9, 8'h10); check("clt", eq, 1);
        do_op(4'hB, 8'hC0); check("cgt", eq, 0);
        do_op(4'hA, 8'hC0); check("cge", eq, 1);
        do_op(4'h9, 8'hFF); check("clt_no", eq, 0);

        // Carry-in wraps to zero
        do_op(4'hE, 8'h00);
        do_op(4'h0, 8'hFF);
        do_op(4'h1, 8'h00);
        check("adc_acc", acc_out, 8'h00);
        check("adc_c",   carry,   1);
        do_op(4'hF, 8'h55);
        check("nop_acc", acc_out, 8'h00);
        do_op(4'hD, 8'h00);
        check("clc_c", carry, 0);

        // Back-to-back stream, START held high
        for (int i = 0; i < 12; i++) do_op(tbl_op[i], tbl_v[i]);
        @(negedge clk);

`ifdef SEQ_ALU_MUL_EN
        do_op(4'h0, 8'hC8);
        do_op(4'hC, 8'h0A);
        n = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (busy) n++;
            if (i == 3) begin start = 1'b1; op = 4'h0; operand = 8'h55; end
            if (i == 5) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("mul_busy_cycles", n, 8);
        check("mul_done", done, 1);
        check("mul_hi",  hi_out,  8'h07);
        check("mul_acc", acc_out, 8'hD0);
        @(negedge clk);
        check("mul_done_once", done, 0);
`else
        do_op(4'hE, 8'h00);
        do_op(4'h0, 8'h5A);
        do_op(4'h8, 8'h5A);
        do_op(4'hC, 8'h33);
        check("opc_done", done, 1);
        check("opc_acc",  acc_out, 8'h5A);
        check("opc_c",    carry, 1);
        check("opc_eq",   eq, 1);
        check("opc_busy", busy, 0);
        check("opc_hi",   hi_out, 0);
        @(negedge clk);
`endif

        // Reset in the middle of a multiply (plain NOP in the default build)
        do_op(4'h0, 8'hC8);
        do_op(4'hC, 8'h0A);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        reset_n = 1'b1;
        do_op(4'h8, 8'h00);
        check("post_reset_ceq", eq, 1);
        check("post_reset_done", done, 1);
        @(negedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout actual=running required=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter W SHALL default to 8: datapath width, legal values 4..32, power of two.
REQ-002 Parameter SW SHALL default to $clog2(W): shift-amount width, derived and not overridden.
REQ-003 CLK SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 RESET_N SHALL be an input, 1 bit: synchronous active-low reset.
REQ-005 START SHALL be an input, 1 bit: command strobe, sampled only when BUSY=0.
REQ-006 OP SHALL be an input, 4 bits: opcode per REQ-012.
REQ-007 OPERAND SHALL be an input, W bits: second operand (the accumulator is the first).
REQ-008 ACC_OUT SHALL be an output, W bits: registered accumulator.
REQ-009 HI_OUT SHALL be an output, W bits: registered upper product half.
REQ-010 CARRY, EQ, BUSY and DONE SHALL be outputs, 1 bit each: carry/not-borrow flag, compare flag, multi-cycle op in progress, one-cycle completion pulse.

Function
REQ-011 Internal state SHALL be ACC, HI, C and EQ registers plus an FSM with states IDLE and MUL; outputs are driven directly from these registers.
REQ-012 Opcodes SHALL be encoded as follows, with sums/differences truncated to W bits:
- 0 LOAD: ACC<=OPERAND.
- 1 ADD: {C,ACC}<=ACC+OPERAND+C.
- 2 SUB: {C,ACC}<=ACC+~OPERAND+C; C=1 means no borrow.
- 3 LSL: ACC<=OPERAND<<ACC[SW-1:0].
- 4 LSR: ACC<=OPERAND>>ACC[SW-1:0], zero fill.
- 5 AND, 6 OR, 7 XOR: bitwise with OPERAND into ACC; C<=0.
- 8 CEQ: EQ<=(OPERAND==ACC).
- 9 CLT: EQ<=(OPERAND<ACC), unsigned.
- A CGE: EQ<=(OPERAND>=ACC), unsigned.
- B CGT: EQ<=(OPERAND>ACC), unsigned.
- C MUL: per REQ-016.
- D CLC: C<=0.
- E SEC: C<=1.
- F NOP.
REQ-013 Each opcode SHALL modify only the registers it names in REQ-012; all other registers hold.
REQ-014 A single-cycle op accepted at edge k SHALL update its registers at edge k; DONE SHALL be 1 for exactly the cycle following k; BUSY SHALL stay 0.
REQ-015 Back-to-back single-cycle ops (START held high) SHALL execute one per cycle, each consuming the previous result.
REQ-016 MUL SHALL run as an unsigned shift-add multiply:
- FSM enters MUL and BUSY=1 from the edge of acceptance.
- Exactly W iterations, one per cycle.
- At completion {HI,ACC}<=ACC*OPERAND, where OPERAND is the value captured at acceptance.
- BUSY falls and DONE pulses in the same cycle that the result appears.
- C and EQ are unchanged.
REQ-017 While BUSY=1, START SHALL be ignored and the command dropped, not queued; changes on OPERAND and OP SHALL not affect the running multiply.
REQ-018 ACC_OUT and HI_OUT SHALL show intermediate values during MUL and are defined only once DONE is high.
REQ-019 A shift amount of 0 SHALL pass OPERAND unchanged; ACC bits above SW-1 SHALL be ignored for shifts.

Reset
REQ-020 When RESET_N=0 at a rising edge, ACC, HI, C, EQ, BUSY and DONE SHALL all become 0 and the FSM SHALL enter IDLE.
REQ-021 Reset SHALL take priority over START and SHALL abort an in-flight MUL with no DONE pulse; START in the first cycle after reset release SHALL be accepted.

Configuration
REQ-022 Macro SEQ_ALU_MUL_EN, when defined, SHALL compile in the MUL state, the HI register and opcode C as specified.
REQ-023 Without SEQ_ALU_MUL_EN, opcode C SHALL behave as NOP (single-cycle DONE pulse, no state change), HI_OUT SHALL be tied to 0, and BUSY SHALL be constant 0.

Verification (W=8)
REQ-024 LOAD 0xF0, then ADD 0x20 with C=0 -> ACC=0x10, C=1, DONE pulses once per op.
REQ-025 LOAD 0x05, then SEC, then SUB 0x07 -> ACC=0xFE, C=0 (borrow).
REQ-026 LOAD 0x03, then LSL 0x81 -> ACC=0x08; LOAD 0x0B, then LSR 0x80 -> ACC=0x10 (shift amount 3).
REQ-027 MUL_EN defined: LOAD 0xC8, then MUL 0x0A -> BUSY=1 for 8 cycles, then HI=0x07, ACC=0xD0, DONE once; a START issued mid-run is dropped.
REQ-028 Assert RESET_N=0 at iteration 4 of a MUL -> next edge all outputs 0, no DONE pulse; a CEQ issued on the next cycle gives EQ=1 (0==0).
REQ-029 MUL_EN undefined: opcode C -> DONE pulses one cycle after acceptance; ACC, C and EQ unchanged; BUSY and HI_OUT stay 0.
